// File: rtl/intr_ctrl.sv
// Programmable interrupt controller: rising edges latch into PENDING, MASK and a
// fixed priority pick one source, and a REQ/ack/CLAIM handshake drives cp0.
module intr_ctrl #(
  parameter int unsigned NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0020
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [31:0]     address,
  input  logic [31:0]     wdata,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            irq_ack,
  output logic [31:0]     rdata,
  output logic            IntrAddress,
  output logic            cpu_irq
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] prev_irq_q;
  logic [3:0]      claim_id_q, claim_id_d;
  logic            active;

  logic            hit_pend, hit_mask, hit_claim;
  logic [NSRC-1:0] rise, elig, win_oh;
  logic [3:0]      win_idx;
  logic            take, complete;

  // Loads are side-effect free, so the read strobe carries no information here.
  logic unused_bits;
  assign unused_bits = ^{MemRead, address[1:0], wdata};

  assign IntrAddress = (address[31:4] == BASE_ADDR[31:4]) && (address[3:2] != 2'b11);
  assign hit_pend    = IntrAddress && (address[3:2] == 2'b00);
  assign hit_mask    = IntrAddress && (address[3:2] == 2'b01);
  assign hit_claim   = IntrAddress && (address[3:2] == 2'b10);

  assign rise     = irq_in & ~prev_irq_q;
  assign elig     = pending_q & mask_q;
  assign take     = (state_q == REQ) && irq_ack && (|elig);
  assign complete = (state_q == SERVICE) && MemWrite && hit_claim
                    && (wdata[3:0] == claim_id_q);

  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    win_idx = '0;
    win_oh  = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        // NOTE: blocking here; later iterations overwrite earlier ones in order.
        win_idx   = 4'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Clears are applied before sets, so a new edge beats W1C or ack in one cycle.
  always_comb begin
    pending_d = pending_q;
    if (MemWrite && hit_pend) pending_d = pending_d & ~wdata[NSRC-1:0];
    if (take)                 pending_d = pending_d & ~win_oh;
    pending_d = pending_d | rise;

    mask_d     = (MemWrite && hit_mask) ? wdata[NSRC-1:0] : mask_q;
    claim_id_d = take ? win_idx : claim_id_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values.
    prev_irq_q <= irq_in;
    if (reset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      claim_id_q <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      claim_id_q <= claim_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|elig) state_d = REQ;
      REQ: begin
        if (take)        state_d = SERVICE;
        else if (~|elig) state_d = IDLE;
      end
      SERVICE: if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_irq = (state_q == REQ);
    active  = (state_q == SERVICE);
  end

  always_comb begin
    rdata = '0;
    if (hit_pend)       rdata = {{(32 - NSRC){1'b0}}, pending_q};
    else if (hit_mask)  rdata = {{(32 - NSRC){1'b0}}, mask_q};
    else if (hit_claim) rdata = {active, 27'b0, claim_id_q};
  end

endmodule
